// File: rtl/mips_pkg.sv
// Shared types for the MIPS memory-port arbiter: FSM state and grant encodings, default widths.
// Pure declarations; no logic, no latency, no flow control.
// Imported by mem_port_arbiter and mem_arb_age.
package mips_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_arb_age.sv
// Starvation guard: counts data grants made while a fetch waits, raises force_if at MAX_RUN.
// Latency: force_if reflects every grant from the following cycle on.
// Backpressure: none; it only observes grants made by the arbiter.
module mem_arb_age
    import mips_pkg::*;
#(
    parameter int MAX_RUN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic gnt_vld,
    input  gnt_t gnt_sel,
    input  logic if_req,
    output logic force_if
);

    localparam int RUN_W = $clog2(MAX_RUN + 1);

    logic [RUN_W-1:0] run_cnt;

    // A data grant with no fetch waiting means nobody is being starved, so the run restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if (gnt_vld) begin
            if (gnt_sel == GNT_IF || !if_req) begin
                run_cnt <= '0;
            end else if (run_cnt != RUN_W'(MAX_RUN)) begin
                run_cnt <= run_cnt + RUN_W'(1);
            end
        end
    end

    assign force_if = (run_cnt == RUN_W'(MAX_RUN));

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF-stage fetches and MEM-stage loads/stores onto one single-ported memory.
// Latency: request seen in IDLE cycle N -> m_en at N+1, ack at N+2+MEM_LAT; back-to-back spacing MEM_LAT+3.
// Backpressure: requests are held until a one-cycle ack; data wins unless a fetch has waited MAX_RUN grants.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = 2,
    parameter int MAX_RUN = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,

    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,

    output logic              busy
);

    localparam int LAT_W = $clog2(MEM_LAT + 1);

    arb_state_t       state;
    arb_state_t       state_nxt;
    gnt_t             gnt_sel;
    gnt_t             owner;
    logic             gnt_vld;
    logic             owner_we;
    logic             force_if;
    logic [LAT_W-1:0] lat_cnt;

    mem_arb_age #(
        .MAX_RUN (MAX_RUN)
    ) u_age (
        .clk      (clk),
        .rst_n    (rst_n),
        .gnt_vld  (gnt_vld),
        .gnt_sel  (gnt_sel),
        .if_req   (if_req),
        .force_if (force_if)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Requests are only looked at in IDLE, so a req still high during RESP is ignored until then.
    always_comb begin
        state_nxt = state;
        gnt_vld   = 1'b0;
        gnt_sel   = GNT_D;
        case (state)
            IDLE: begin
                if (d_req && !(if_req && force_if)) begin
                    gnt_vld = 1'b1;
                    gnt_sel = GNT_D;
                end else if (if_req) begin
                    gnt_vld = 1'b1;
                    gnt_sel = GNT_IF;
                end
                if (gnt_vld) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (lat_cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Memory strobe and its qualifiers live for the single cycle after the grant and are zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= GNT_IF;
            owner_we <= 1'b0;
            lat_cnt  <= '0;
            m_en     <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
            busy     <= 1'b0;
        end else begin
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            if_ack  <= 1'b0;
            d_ack   <= 1'b0;
            busy    <= (state_nxt != IDLE);

            if (gnt_vld) begin
                owner    <= gnt_sel;
                owner_we <= (gnt_sel == GNT_D) && d_we;
                lat_cnt  <= LAT_W'(MEM_LAT);
                m_en     <= 1'b1;
                if (gnt_sel == GNT_D) begin
                    m_we    <= d_we;
                    m_addr  <= d_addr;
                    m_wdata <= d_we ? d_wdata : '0;
                end else begin
                    m_addr  <= if_addr;
                end
            end else if (state == ACCESS) begin
                if (lat_cnt == '0) begin
                    if (owner == GNT_IF) begin
                        if_rdata <= m_rdata;
                        if_ack   <= 1'b1;
                    end else begin
                        d_ack <= 1'b1;
                        if (!owner_we) begin
                            d_rdata <= m_rdata;
                        end
                    end
                end else begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a schedule-based reference model checked every cycle plus directed scenarios.
// Memory is modelled behaviourally with a fixed read latency; off-latency cycles drive junk on m_rdata.
module tb_mem_port_arbiter;

    localparam int MEM_LAT = 2;
    localparam int MAX_RUN = 2;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        busy;

    int vectors;
    int miscompares;
    int cyc;
    int n_if_ack;
    int n_d_ack;
    int men_log[$];
    int iack_log[$];
    int dack_log[$];

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .MEM_LAT (MEM_LAT),
        .MAX_RUN (MAX_RUN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required to finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [31:0] init_word(input logic [31:0] a);
        case (a)
            32'h40:  return 32'hDEAD;
            32'h44:  return 32'h1111;
            32'h100: return 32'hBEEF;
            default: return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    // Environment memory (driven by what the DUT actually issues) and the model's own copy.
    logic [31:0] env_mem[logic [31:0]];
    logic [31:0] mdl_mem[logic [31:0]];

    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : init_word(a);
    endfunction

    bit          dlv_pend;
    int          dlv_cyc;
    logic [31:0] dlv_dat;

    // Reference model: one access at a time, described by the cycles at which its events must occur.
    bit          inflight;
    int          en_cyc;
    int          ack_cyc;
    bit          acc_d;
    bit          acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [31:0] acc_rd;
    int          run;
    logic [31:0] e_if_rdata;
    logic [31:0] e_d_rdata;

    always @(negedge clk) begin : monitor
        bit   e_men;
        bit   e_ack;
        bit   idle_now;
        bit   pick_d;

        if (dlv_pend && dlv_cyc == cyc) begin
            m_rdata  = dlv_dat;
            dlv_pend = 1'b0;
        end else begin
            m_rdata = 32'hBAD0_0000 | 32'(cyc & 16'hFFFF);
        end
        if (m_en) begin
            dlv_pend = 1'b1;
            dlv_cyc  = cyc + MEM_LAT;
            dlv_dat  = env_rd(m_addr);
            if (m_we) env_mem[m_addr] = m_wdata;
            men_log.push_back(cyc);
        end
        if (if_ack) begin
            iack_log.push_back(cyc);
            n_if_ack++;
        end
        if (d_ack) begin
            dack_log.push_back(cyc);
            n_d_ack++;
        end

        if (!rst_n) begin
            inflight   = 1'b0;
            run        = 0;
            e_if_rdata = '0;
            e_d_rdata  = '0;
        end

        e_men = inflight && (cyc == en_cyc);
        e_ack = inflight && (cyc == ack_cyc);
        if (e_ack && !acc_d) e_if_rdata = acc_rd;
        if (e_ack && acc_d && !acc_we) e_d_rdata = acc_rd;

        check("m_en", m_en, e_men);
        check("m_we", m_we, e_men && acc_we);
        check("m_addr", m_addr, e_men ? acc_addr : 32'h0);
        if (!(e_men && !acc_we)) check("m_wdata", m_wdata, e_men ? acc_wdata : 32'h0);
        check("busy", busy, inflight);
        check("if_ack", if_ack, e_ack && !acc_d);
        check("d_ack", d_ack, e_ack && acc_d);
        check("if_rdata", if_rdata, e_if_rdata);
        check("d_rdata", d_rdata, e_d_rdata);

        idle_now = !inflight;
        if (e_ack) inflight = 1'b0;

        if (rst_n && idle_now && (if_req || d_req)) begin
            pick_d    = d_req && !(if_req && run == MAX_RUN);
            acc_d     = pick_d;
            acc_we    = pick_d && d_we;
            acc_addr  = pick_d ? d_addr : if_addr;
            acc_wdata = d_wdata;
            acc_rd    = mdl_rd(acc_addr);
            if (acc_we) mdl_mem[acc_addr] = acc_wdata;
            if (pick_d && if_req) run = (run < MAX_RUN) ? run + 1 : MAX_RUN;
            else run = 0;
            inflight = 1'b1;
            en_cyc   = cyc + 1;
            ack_cyc  = cyc + 2 + MEM_LAT;
        end

        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        men_log.delete();
        iack_log.delete();
        dack_log.delete();
    endtask

    task automatic fetch_req(input logic [31:0] addr);
        int target;
        int n;
        if_req  = 1'b1;
        if_addr = addr;
        target  = n_if_ack + 1;
        n       = 0;
        do begin
            tick();
            n++;
        end while (n_if_ack < target && n < 60);
        check("fetch_ack_seen", n_if_ack >= target, 1);
        if_req  = 1'b0;
        if_addr = '0;
    endtask

    task automatic data_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input bit keep);
        int target;
        int n;
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        target  = n_d_ack + 1;
        n       = 0;
        do begin
            tick();
            n++;
        end while (n_d_ack < target && n < 60);
        check("data_ack_seen", n_d_ack >= target, 1);
        if (!keep) begin
            d_req   = 1'b0;
            d_we    = 1'b0;
            d_addr  = '0;
            d_wdata = '0;
        end
    endtask

    int c0;

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; n_if_ack = 0; n_d_ack = 0;
        dlv_pend = 1'b0; inflight = 1'b0; run = 0;
        e_if_rdata = '0; e_d_rdata = '0;
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; m_rdata = '0;

        repeat (3) tick();
        check("reset_busy", busy, 0);
        check("reset_m_en", m_en, 0);
        rst_n = 1'b1;
        tick();

        // Lone fetch
        clear_logs(); c0 = cyc;
        fetch_req(32'h40);
        check("lone_men_cyc", at(men_log, 0), c0 + 1);
        check("lone_ack_cyc", at(iack_log, 0), c0 + 4);
        check("lone_if_rdata", if_rdata, 32'hDEAD);

        // Simultaneous fetch and load
        tick(); clear_logs(); c0 = cyc;
        fork
            fetch_req(32'h44);
            data_req(1'b0, 32'h100, 32'h0, 1'b0);
        join
        check("sim_dack_cyc", at(dack_log, 0), c0 + 4);
        check("sim_if_men_cyc", at(men_log, 1), c0 + 6);
        check("sim_iack_cyc", at(iack_log, 0), c0 + 9);
        check("sim_d_rdata", d_rdata, 32'hBEEF);
        check("sim_if_rdata", if_rdata, 32'h1111);

        // Starvation guard: data held continuously while a fetch waits
        tick(); clear_logs(); c0 = cyc;
        fork
            fetch_req(32'h48);
            begin
                data_req(1'b0, 32'h200, 32'h0, 1'b1);
                data_req(1'b0, 32'h204, 32'h0, 1'b1);
                data_req(1'b0, 32'h208, 32'h0, 1'b1);
                data_req(1'b0, 32'h20C, 32'h0, 1'b0);
            end
        join
        check("starve_dack0", at(dack_log, 0), c0 + 4);
        check("starve_dack1", at(dack_log, 1), c0 + 9);
        check("starve_iack", at(iack_log, 0), c0 + 14);
        check("starve_dack2", at(dack_log, 2), c0 + 19);
        check("starve_nacks", dack_log.size(), 4);

        // Store
        tick(); clear_logs(); c0 = cyc;
        data_req(1'b1, 32'h20, 32'h55, 1'b0);
        check("st_men_count", men_log.size(), 1);
        check("st_dack_cyc", at(dack_log, 0), c0 + 4);
        check("st_dack_after_men", at(dack_log, 0), at(men_log, 0) + 3);
        check("st_d_rdata_kept", d_rdata, 32'hA5A5_020C);

        // Reset in the second ACCESS cycle
        tick(); clear_logs(); c0 = cyc;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        tick(); tick();
        rst_n = 1'b0; d_req = 1'b0; d_addr = '0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_d_rdata", d_rdata, 0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("rst_no_ack", dack_log.size(), 0);
        clear_logs(); c0 = cyc;
        data_req(1'b0, 32'h20, 32'h0, 1'b0);
        check("post_rst_men_cyc", at(men_log, 0), c0 + 1);
        check("post_rst_dack_cyc", at(dack_log, 0), c0 + 4);
        check("post_rst_load_sw", d_rdata, 32'h55);

        // Back-to-back data with the request held across the ack
        tick(); clear_logs(); c0 = cyc;
        data_req(1'b0, 32'h40, 32'h0, 1'b1);
        data_req(1'b0, 32'h44, 32'h0, 1'b0);
        check("b2b_first_men", at(men_log, 0), c0 + 1);
        check("b2b_gap", at(men_log, 1) - at(men_log, 0), 5);
        check("b2b_d_rdata", d_rdata, 32'h1111);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
